// File: rtl/hazard_seq_ctrl_if.sv
// Hazard sequencer bus: request lines from the pipeline and the
// stage enable/flush controls plus the stall statistic back to it.
interface hazard_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             fwd_stall;
    logic             branch_taken;
    logic             md_start;
    logic             cnt_clr;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             md_busy;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side: raises hazard requests, obeys the stage controls.
    modport master (
        output fwd_stall,
        output branch_taken,
        output md_start,
        output cnt_clr,
        input  pc_en,
        input  ifid_en,
        input  ifid_flush,
        input  idex_en,
        input  idex_flush,
        input  md_busy,
        input  stall_count
    );

    // Controller side: reads the requests, drives the stage controls.
    modport slave (
        input  fwd_stall,
        input  branch_taken,
        input  md_start,
        input  cnt_clr,
        output pc_en,
        output ifid_en,
        output ifid_flush,
        output idex_en,
        output idex_flush,
        output md_busy,
        output stall_count
    );
endinterface

// File: rtl/hazard_seq_ctrl.sv
// Pipeline hazard sequencer: arbitrates multi-cycle mult/div occupancy,
// forwarding stalls and taken-branch squashes into per-stage enables and
// flushes, and keeps a saturating count of cycles the PC was frozen.
module hazard_seq_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_seq_ctrl_if.slave  bus
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // The accepting RUN cycle is the first busy cycle, so the wait state
    // only has to cover the remaining MD_LATENCY-1 cycles.
    localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 1);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       md_cnt_q;
    logic [3:0]       md_cnt_d;
    logic [CNT_W-1:0] stall_q;

    logic pc_en_c;
    logic ifid_en_c;
    logic ifid_flush_c;
    logic idex_en_c;
    logic idex_flush_c;
    logic md_busy_c;

    // State and mult/div countdown registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Next-state and Mealy stage controls; priority is mult/div, then the
    // forwarding stall, then the taken branch.
    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        ifid_flush_c = 1'b0;
        idex_en_c    = 1'b1;
        idex_flush_c = 1'b0;
        md_busy_c    = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.md_start) begin
                    pc_en_c   = 1'b0;
                    ifid_en_c = 1'b0;
                    idex_en_c = 1'b0;
                    md_busy_c = 1'b1;
                    state_d   = MD_WAIT;
                    md_cnt_d  = MD_INIT;
                end else if (bus.fwd_stall) begin
                    // Hold IF and ID; push a bubble into EX. A concurrent
                    // branch is seen again next cycle since ID is held.
                    pc_en_c      = 1'b0;
                    ifid_en_c    = 1'b0;
                    idex_flush_c = 1'b1;
                end else if (bus.branch_taken) begin
                    ifid_flush_c = 1'b1;
                end
            end
            MD_WAIT: begin
                // Whole front end frozen; new requests are not looked at.
                pc_en_c   = 1'b0;
                ifid_en_c = 1'b0;
                idex_en_c = 1'b0;
                md_busy_c = 1'b1;
                md_cnt_d  = md_cnt_q - 4'd1;
                if (md_cnt_q == 4'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = 4'd0;
            end
        endcase
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (bus.cnt_clr) begin
            stall_q <= '0;
        end else if (!pc_en_c && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    // Every control is held low for as long as reset is asserted.
    assign bus.pc_en       = rst_n & pc_en_c;
    assign bus.ifid_en     = rst_n & ifid_en_c;
    assign bus.ifid_flush  = rst_n & ifid_flush_c;
    assign bus.idex_en     = rst_n & idex_en_c;
    assign bus.idex_flush  = rst_n & idex_flush_c;
    assign bus.md_busy     = rst_n & md_busy_c;
    assign bus.stall_count = stall_q;

endmodule
